// File: rtl/ad_sample_avg.sv
// ad_sample_avg: block-averages AD7683 conversions on chip-select rising edges.
// Results are presented with a valid/ready handshake and a sticky overrun flag.
module ad_sample_avg #(
    parameter int AVG_LOG2 = 2
) (
    input  logic        userclk,
    input  logic        rst,
    input  logic        en,
    input  logic        adcs,
    input  logic [15:0] addata,
    output logic [15:0] avg_data,
    output logic        avg_valid,
    input  logic        avg_ready,
    output logic        overrun,
    input  logic        ovr_clr
);
    localparam int CW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
    localparam int AW = 16 + AVG_LOG2;
    localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);

    typedef enum logic {WARMUP, ACCUM} state_t;

    state_t        state;
    logic          adcs_d;
    logic [AW-1:0] acc;
    logic [AW-1:0] sum;
    logic [CW-1:0] cnt;
    logic          stb;
    logic          load;

    assign stb  = adcs & ~adcs_d;
    assign sum  = acc + AW'(addata);
    assign load = en & stb & (state == ACCUM) & (cnt == LAST);

    always_ff @(posedge userclk) begin
        if (rst) begin
            state     <= WARMUP;
            adcs_d    <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
            avg_data  <= 16'h0000;
            avg_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            adcs_d <= adcs;
            if (!en) begin
                state <= WARMUP;
                acc   <= '0;
                cnt   <= '0;
            end else if (stb) begin
                // First edge after reset/enable carries no valid conversion
                if (state == WARMUP) state <= ACCUM;
                else begin
                    acc <= load ? '0 : sum;
                    cnt <= load ? '0 : cnt + CW'(1);
                end
            end
            if (load) avg_data <= 16'(sum >> AVG_LOG2);
            avg_valid <= load | (avg_valid & ~avg_ready);
            overrun   <= ~ovr_clr & (overrun | (load & avg_valid & ~avg_ready));
        end
    end
endmodule

// File: doc/ad_sample_avg.md
AD_SAMPLE_AVG -- requirements
Module: ad_sample_avg

Interface
REQ-001 Parameter AVG_LOG2, default 2, log2 of samples averaged per output word; legal range 0..6.
REQ-002 userclk  input  1  system clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  averaging enable.
REQ-005 adcs  input  1  ADC chip-select from the AD7683 reader; a rising edge marks a completed 16-bit conversion.
REQ-006 addata  input  16  conversion word from the AD7683 reader; stable while adcs is high.
REQ-007 avg_data  output  16  averaged sample, unsigned.
REQ-008 avg_valid  output  1  avg_data holds an unconsumed result.
REQ-009 avg_ready  input  1  consumer accepts avg_data when high together with avg_valid.
REQ-010 overrun  output  1  sticky flag; an unconsumed result was overwritten.
REQ-011 ovr_clr  input  1  clears overrun.

Function
REQ-012 The block SHALL register adcs once (adcs_d) and define a sample strobe stb = adcs & ~adcs_d, sampling addata in the same cycle.
REQ-013 The FSM SHALL have states WARMUP and ACCUM, where WARMUP discards exactly one stb and then moves to ACCUM, because the first chip-select edge after reset or enable carries no valid conversion.
REQ-014 In ACCUM, each stb SHALL add addata to an unsigned accumulator of 16+AVG_LOG2 bits and increment a sample counter of max(AVG_LOG2,1) bits.
REQ-015 On the stb that completes 2^AVG_LOG2 samples, the block SHALL register avg_data = (acc + addata) >> AVG_LOG2 (truncation, no rounding), set avg_valid on the next clock edge, and clear acc and the counter in the same edge.
REQ-016 Latency from the final-sample stb cycle to avg_valid high SHALL be exactly 1 clock.
REQ-017 With AVG_LOG2 = 0, every stb in ACCUM SHALL produce avg_data = addata.
REQ-018 The accumulator SHALL never overflow, since its width covers 2^AVG_LOG2 × 0xFFFF.
REQ-019 A handshake occurs when avg_valid & avg_ready, after which avg_valid SHALL drop on the next edge unless a new result loads in that same edge.
REQ-020 A new result loading while avg_valid=1 and avg_ready=0 SHALL overwrite avg_data, keep avg_valid=1, and set overrun=1.
REQ-021 A new result loading in the same cycle as a handshake SHALL keep avg_valid=1 and SHALL NOT set overrun.
REQ-022 avg_data SHALL hold its value while avg_valid=1 and no new result loads.
REQ-023 overrun SHALL stay set until ovr_clr=1, and ovr_clr SHALL take priority over a simultaneous set.
REQ-024 When en=0, the FSM SHALL go to WARMUP and clear acc and the counter on the next edge, ignoring stb; avg_data, avg_valid, and overrun SHALL be unaffected and the handshake SHALL continue to work.
REQ-025 en deasserting in mid-block SHALL discard the partial sum, and no partial average SHALL ever be output.
REQ-026 adcs held high for multiple cycles SHALL generate exactly one stb.

Reset
REQ-027 While rst=1, the block SHALL set state=WARMUP, adcs_d=1, acc=0, counter=0, avg_data=0x0000, avg_valid=0, and overrun=0.
REQ-028 adcs_d resetting to 1 SHALL ensure that adcs already high at reset release produces no stb.
REQ-029 rst SHALL take priority over en, stb, avg_ready, and ovr_clr.
REQ-030 rst asserted in mid-accumulation SHALL discard the partial sum.

Verification
REQ-031 Warmup discard: AVG_LOG2=2, en=1; stb sequence 0xFFFF (discarded), 0x0010, 0x0020, 0x0030, 0x0041 -> one cycle after the 5th stb, avg_valid=1 and avg_data=0x0028 (0xA1>>2).
REQ-032 Full-scale: 4 valid samples of 0xFFFF after warmup -> avg_data=0xFFFF with no wrap.
REQ-033 Overrun and clear: avg_ready=0 across two completed blocks (0x0004 ×4, then 0x0008 ×4) -> avg_data=0x0008, avg_valid=1, overrun=1; ovr_clr pulse -> overrun=0, avg_data unchanged.
REQ-034 Simultaneous load and handshake: avg_ready=1 in the same cycle a new result loads -> avg_valid stays 1, new value present, overrun stays 0.
REQ-035 Enable drop: en=0 after 2 of 4 samples, then en=1 -> first stb discarded, next 4 samples averaged, no output produced from the partial block.
REQ-036 Reset mid-block: rst pulse after 3 samples -> all outputs 0; adcs high at reset release yields no stb; a full warmup plus 4 samples is required before the next avg_valid.
